nios2_oci_trace_fifo: RTL and testbench

//  Trace-message FIFO for the OCI trace path. Each cycle it accepts 0..3 packed trace words
//  (tm_count with tm_data0..2) from the trace packer and drains at most one word per cycle
//  to the trace output port. It owns the write pointer, read pointer and occupancy counter.
//  It generates the empty/free2/free3 status that the occupancy-increment logic consumes,
//  and it keeps a sticky overflow flag.

---
 rtl/nios2_oci_trace_fifo.sv | 99 +++++++++
 tb/tb_nios2_oci_trace_fifo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_oci_trace_fifo.sv
// OCI trace-message FIFO: takes 0..3 packed words per cycle, drains one.
// Packets that do not fit are dropped whole and latch a sticky overflow.
module nios2_oci_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 36,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       tm_count,
  input  logic [WIDTH-1:0] tm_data0,
  input  logic [WIDTH-1:0] tm_data1,
  input  logic [WIDTH-1:0] tm_data2,
  input  logic             rd_en,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_valid,
  output logic [CNTW-1:0]  fifocount,
  output logic             empty,
  output logic             free2,
  output logic             free3,
  output logic             tm_ovf
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW-1:0]   PTR1    = AW'(1);
  localparam logic [AW-1:0]   PTR2    = AW'(2);
  localparam logic [CNTW:0]   DEPTH_W = (CNTW+1)'(DEPTH);
  localparam logic [CNTW-1:0] LIM2    = CNTW'(DEPTH - 2);
  localparam logic [CNTW-1:0] LIM3    = CNTW'(DEPTH - 3);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]   wrptr;
  logic [AW-1:0]   rdptr;
  logic [CNTW-1:0] count_next;
  logic [CNTW:0]   avail;
  logic [1:0]      acc;
  logic            pop;
  logic            accept;
  logic            drop;

  assign empty      = (fifocount == '0);
  assign fifo_valid = ~empty;
  assign free2      = (fifocount <= LIM2);
  assign free3      = (fifocount <= LIM3);
  assign fifo_rdata = empty ? '0 : mem[rdptr];

  assign pop = rd_en & ~empty;

  // A pop in this cycle frees its slot for the incoming packet.
  assign avail = DEPTH_W
               - {1'b0, fifocount}
               + {{CNTW{1'b0}}, pop};

  assign accept = ({{(CNTW-1){1'b0}}, tm_count} <= avail);
  assign drop   = ~accept;
  assign acc    = accept ? tm_count : 2'd0;

  assign count_next = fifocount
                    + {{(CNTW-2){1'b0}}, acc}
                    - {{(CNTW-1){1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      wrptr     <= '0;
      rdptr     <= '0;
      fifocount <= '0;
    end else begin
      wrptr     <= wrptr + AW'(acc);
      fifocount <= count_next;
      if (pop)
        rdptr <= rdptr + PTR1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      tm_ovf <= 1'b0;
    else if (drop)
      tm_ovf <= 1'b1;
    else if (ovf_clr)
      tm_ovf <= 1'b0;
  end

  // Storage is not reset; pointer wrap handles straddling writes.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      if (acc != 2'd0)
        mem[wrptr] <= tm_data0;
      if (acc >= 2'd2)
        mem[wrptr + PTR1] <= tm_data1;
      if (acc == 2'd3)
        mem[wrptr + PTR2] <= tm_data2;
    end
  end

endmodule

// File: tb/tb_nios2_oci_trace_fifo.sv
// Directed bench for the OCI trace FIFO.
// Vector table plus hand sequences for fill, wrap and overflow.
module tb_nios2_oci_trace_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  tm_count;
  logic [35:0] tm_data0;
  logic [35:0] tm_data1;
  logic [35:0] tm_data2;
  logic        rd_en;
  logic        ovf_clr;
  logic [35:0] fifo_rdata;
  logic        fifo_valid;
  logic [4:0]  fifocount;
  logic        empty;
  logic        free2;
  logic        free3;
  logic        tm_ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nios2_oci_trace_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .tm_count  (tm_count),
    .tm_data0  (tm_data0),
    .tm_data1  (tm_data1),
    .tm_data2  (tm_data2),
    .rd_en     (rd_en),
    .ovf_clr   (ovf_clr),
    .fifo_rdata(fifo_rdata),
    .fifo_valid(fifo_valid),
    .fifocount (fifocount),
    .empty     (empty),
    .free2     (free2),
    .free3     (free3),
    .tm_ovf    (tm_ovf)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  cnt;
    logic [35:0] d0;
    logic [35:0] d1;
    logic [35:0] d2;
    logic        rd;
    logic        clr;
    logic [4:0]  ecount;
    logic        evalid;
    logic [35:0] erdata;
    logic        eovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] c,
                      input logic [35:0] a, input logic [35:0] b,
                      input logic [35:0] d, input logic rd,
                      input logic clr);
    reset    = r;
    tm_count = c;
    tm_data0 = a;
    tm_data1 = b;
    tm_data2 = d;
    rd_en    = rd;
    ovf_clr  = clr;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    tm_count = 2'd0;
    rd_en    = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  task automatic do_reset();
    step(1'b1, 2'd0, 36'h0, 36'h0, 36'h0, 1'b0, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    tm_count = 2'd0;
    tm_data0 = '0;
    tm_data1 = '0;
    tm_data2 = '0;
    rd_en    = 1'b0;
    ovf_clr  = 1'b0;

    vecs[0] = '{1'b1, 2'd0, 36'h0, 36'h0, 36'h0, 1'b0, 1'b0,
                5'd0, 1'b0, 36'h0, 1'b0};
    vecs[1] = '{1'b0, 2'd2, 36'hA1, 36'hA2, 36'h0, 1'b0, 1'b0,
                5'd2, 1'b1, 36'hA1, 1'b0};
    vecs[2] = '{1'b0, 2'd0, 36'h0, 36'h0, 36'h0, 1'b1, 1'b0,
                5'd1, 1'b1, 36'hA2, 1'b0};
    vecs[3] = '{1'b0, 2'd1, 36'hA3, 36'h0, 36'h0, 1'b1, 1'b0,
                5'd1, 1'b1, 36'hA3, 1'b0};
    vecs[4] = '{1'b0, 2'd0, 36'h0, 36'h0, 36'h0, 1'b1, 1'b0,
                5'd0, 1'b0, 36'h0, 1'b0};
    vecs[5] = '{1'b0, 2'd0, 36'h0, 36'h0, 36'h0, 1'b1, 1'b0,
                5'd0, 1'b0, 36'h0, 1'b0};
    vecs[6] = '{1'b0, 2'd3, 36'hB1, 36'hB2, 36'hB3, 1'b1, 1'b0,
                5'd3, 1'b1, 36'hB1, 1'b0};
    vecs[7] = '{1'b1, 2'd2, 36'hEE, 36'hEF, 36'h0, 1'b0, 1'b0,
                5'd0, 1'b0, 36'h0, 1'b0};
    vecs[8] = '{1'b0, 2'd1, 36'hC1, 36'h0, 36'h0, 1'b0, 1'b0,
                5'd1, 1'b1, 36'hC1, 1'b0};
    vecs[9] = '{1'b0, 2'd0, 36'h0, 36'h0, 36'h0, 1'b1, 1'b0,
                5'd0, 1'b0, 36'h0, 1'b0};

    do_reset();
    chk("rst_count", 64'(fifocount), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_free2", 64'(free2), 64'd1);
    chk("rst_free3", 64'(free3), 64'd1);
    chk("rst_ovf", 64'(tm_ovf), 64'd0);

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].rst, vecs[i].cnt, vecs[i].d0, vecs[i].d1,
           vecs[i].d2, vecs[i].rd, vecs[i].clr);
      chk($sformatf("vec%0d_count", i), 64'(fifocount),
          64'(vecs[i].ecount));
      chk($sformatf("vec%0d_valid", i), 64'(fifo_valid),
          64'(vecs[i].evalid));
      chk($sformatf("vec%0d_rdata", i), 64'(fifo_rdata),
          64'(vecs[i].erdata));
      chk($sformatf("vec%0d_ovf", i), 64'(tm_ovf),
          64'(vecs[i].eovf));
    end

    // fill with single words, then drain in order
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 2'd1, 36'(i), 36'h0, 36'h0, 1'b0, 1'b0);
      chk($sformatf("fill%0d_count", i), 64'(fifocount), 64'(i + 1));
      chk($sformatf("fill%0d_free2", i), 64'(free2),
          64'((i + 1) <= 14));
      chk($sformatf("fill%0d_free3", i), 64'(free3),
          64'((i + 1) <= 13));
    end
    chk("fill_ovf", 64'(tm_ovf), 64'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_rdata", i), 64'(fifo_rdata), 64'(i));
      chk($sformatf("drain%0d_valid", i), 64'(fifo_valid), 64'd1);
      step(1'b0, 2'd0, 36'h0, 36'h0, 36'h0, 1'b1, 1'b0);
    end
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_rdata0", 64'(fifo_rdata), 64'd0);

    // three-in one-out climbs by two until full, then drops
    do_reset();
    step(1'b0, 2'd2, 36'h100, 36'h101, 36'h0, 1'b0, 1'b0);
    chk("climb_start", 64'(fifocount), 64'd2);
    for (int k = 2; k <= 7; k++) begin
      step(1'b0, 2'd3, 36'h1, 36'h2, 36'h3, 1'b1, 1'b0);
      chk($sformatf("climb%0d_count", k), 64'(fifocount), 64'(2 * k));
    end
    chk("climb14_free3", 64'(free3), 64'd0);
    chk("climb14_free2", 64'(free2), 64'd1);
    step(1'b0, 2'd3, 36'h1, 36'h2, 36'h3, 1'b1, 1'b0);
    chk("climb_full", 64'(fifocount), 64'd16);
    chk("climb_full_ovf", 64'(tm_ovf), 64'd0);
    chk("climb_full_free2", 64'(free2), 64'd0);
    step(1'b0, 2'd3, 36'h1, 36'h2, 36'h3, 1'b1, 1'b0);
    chk("climb_drop_count", 64'(fifocount), 64'd15);
    chk("climb_drop_ovf", 64'(tm_ovf), 64'd1);

    // full with pop: single word accepted, pair dropped
    step(1'b0, 2'd1, 36'h5, 36'h0, 36'h0, 1'b0, 1'b1);
    chk("refill_count", 64'(fifocount), 64'd16);
    chk("refill_ovfclr", 64'(tm_ovf), 64'd0);
    step(1'b0, 2'd1, 36'h6, 36'h0, 36'h0, 1'b1, 1'b0);
    chk("full1_count", 64'(fifocount), 64'd16);
    chk("full1_ovf", 64'(tm_ovf), 64'd0);
    step(1'b0, 2'd2, 36'h7, 36'h8, 36'h0, 1'b1, 1'b0);
    chk("full2_count", 64'(fifocount), 64'd15);
    chk("full2_ovf", 64'(tm_ovf), 64'd1);

    // drop wins over a simultaneous clear
    step(1'b0, 2'd2, 36'h9, 36'hA, 36'h0, 1'b0, 1'b1);
    chk("clrdrop_ovf", 64'(tm_ovf), 64'd1);
    chk("clrdrop_count", 64'(fifocount), 64'd15);
    step(1'b0, 2'd0, 36'h0, 36'h0, 36'h0, 1'b0, 1'b1);
    chk("clr_ovf", 64'(tm_ovf), 64'd0);

    // pointer wrap: park both pointers at 15, write across the end
    do_reset();
    for (int k = 0; k < 5; k++)
      step(1'b0, 2'd3, 36'h0, 36'h0, 36'h0, 1'b0, 1'b0);
    chk("pre_wrap_count", 64'(fifocount), 64'd15);
    for (int k = 0; k < 15; k++)
      step(1'b0, 2'd0, 36'h0, 36'h0, 36'h0, 1'b1, 1'b0);
    chk("pre_wrap_empty", 64'(empty), 64'd1);
    step(1'b0, 2'd3, 36'hAAA, 36'hBBB, 36'hCCC, 1'b0, 1'b0);
    chk("wrap_count", 64'(fifocount), 64'd3);
    chk("wrap_a", 64'(fifo_rdata), 64'hAAA);
    step(1'b0, 2'd0, 36'h0, 36'h0, 36'h0, 1'b1, 1'b0);
    chk("wrap_b", 64'(fifo_rdata), 64'hBBB);
    step(1'b0, 2'd0, 36'h0, 36'h0, 36'h0, 1'b1, 1'b0);
    chk("wrap_c", 64'(fifo_rdata), 64'hCCC);
    step(1'b0, 2'd1, 36'hDDD, 36'h0, 36'h0, 1'b1, 1'b0);
    chk("wrap_wr2", 64'(fifo_rdata), 64'hDDD);
    chk("wrap_wr2_count", 64'(fifocount), 64'd1);

    // reset with pending count and a push in the same cycle
    do_reset();
    for (int k = 0; k < 3; k++)
      step(1'b0, 2'd3, 36'h11, 36'h22, 36'h33, 1'b0, 1'b0);
    chk("mid_count9", 64'(fifocount), 64'd9);
    step(1'b1, 2'd2, 36'h44, 36'h55, 36'h0, 1'b0, 1'b0);
    chk("mid_rst_count", 64'(fifocount), 64'd0);
    chk("mid_rst_empty", 64'(empty), 64'd1);
    chk("mid_rst_valid", 64'(fifo_valid), 64'd0);
    chk("mid_rst_rdata", 64'(fifo_rdata), 64'd0);
    step(1'b0, 2'd1, 36'h66, 36'h0, 36'h0, 1'b0, 1'b0);
    chk("post_rst_rdata", 64'(fifo_rdata), 64'h66);
    chk("post_rst_count", 64'(fifocount), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
